// File: rtl/alu_sched_pkg.sv
// Shared types for the ALU scheduler: op encodings, FSM states and the
// function that packs raw ALU outputs into a result/carry pair.
package alu_sched_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_CMP = 2'b10,
        OP_AND = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } state_e;

    typedef struct packed {
        logic       carry;
        logic [3:0] result;
    } alu_out_t;

    function automatic alu_out_t pack_result(
        input op_e        op,
        input logic [3:0] sas,
        input logic       cas,
        input logic       aeqb,
        input logic       a_greater_b,
        input logic       b_greater_a,
        input logic [3:0] a_and_b
    );
        alu_out_t r;
        r = '0;
        case (op)
            OP_ADD, OP_SUB: begin
                r.result = sas;
                r.carry  = cas;
            end
            OP_CMP: r.result = {1'b0, b_greater_a, aeqb, a_greater_b};
            OP_AND: r.result = a_and_b;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_verilog.sv
// Shared 4-bit combinational ALU: add/sub on SAS/CAS plus compare and AND
// outputs that are always available regardless of the select lines.
module alu_verilog (
    input  logic       s1,
    input  logic       s0,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] sas,
    output logic       cas,
    output logic       aeqb,
    output logic       a_greater_b,
    output logic       b_greater_a,
    output logic [3:0] a_and_b
);

    logic [4:0] sum;

    // Subtract as A + ~B + 1 so the carry out reads as "no borrow" (A >= B).
    always_comb begin
        sum = '0;
        if (s0 && !s1) sum = {1'b0, a} + {1'b0, ~b} + 5'd1;
        else           sum = {1'b0, a} + {1'b0, b};
    end

    assign sas         = sum[3:0];
    assign cas         = sum[4];
    assign aeqb        = (a == b);
    assign a_greater_b = (a > b);
    assign b_greater_a = (b > a);
    assign a_and_b     = a & b;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last grant and wraps;
// the pointer moves to the winner whenever the advance strobe is high.
module rr_arbiter #(
    parameter int unsigned N_REQ = 2,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic             found;
    int unsigned      idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (32'(ptr_q) + k) % N_REQ;
            if (!found && req[IDX_W'(idx)]) begin
                found                 = 1'b1;
                grant[IDX_W'(idx)]    = 1'b1;
                grant_idx             = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)       ptr_q <= IDX_W'(N_REQ - 1);
        else if (advance) ptr_q <= grant_idx;
    end

endmodule

// File: rtl/alu_scheduler.sv
// Front end for the shared ALU: round-robin accepts one request at a time,
// registers operands into the ALU, captures the packed result and returns it.
module alu_scheduler
    import alu_sched_pkg::*;
#(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned DATA_W = 4,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [2*N_REQ-1:0]      req_op,
    input  logic [DATA_W*N_REQ-1:0] req_a,
    input  logic [DATA_W*N_REQ-1:0] req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDX_W-1:0]        rsp_id,
    output logic [DATA_W-1:0]       rsp_result,
    output logic                    rsp_carry,
    output logic                    busy
);

    state_e              state_q, state_d;
    op_e                 op_q;
    logic [DATA_W-1:0]   a_q, b_q, result_q;
    logic [IDX_W-1:0]    id_q;
    logic                carry_q;

    logic [N_REQ-1:0]    grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                accept;
    logic [1:0]          sel_op;
    logic [DATA_W-1:0]   sel_a, sel_b;

    logic [3:0]          sas, a_and_b;
    logic                cas, aeqb, a_gt_b, b_gt_a;
    alu_out_t            packed_out;

    assign accept = (state_q == IDLE) && rst_n && (|req_valid);

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_op = req_op[2*i +: 2];
                sel_a  = req_a[DATA_W*i +: DATA_W];
                sel_b  = req_b[DATA_W*i +: DATA_W];
            end
        end
    end

    alu_verilog u_alu (
        .s1          (op_q[1]),
        .s0          (op_q[0]),
        .a           (a_q),
        .b           (b_q),
        .sas         (sas),
        .cas         (cas),
        .aeqb        (aeqb),
        .a_greater_b (a_gt_b),
        .b_greater_a (b_gt_a),
        .a_and_b     (a_and_b)
    );

    assign packed_out = pack_result(op_q, sas, cas, aeqb, a_gt_b, b_gt_a, a_and_b);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req_valid) state_d = ISSUE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= op_e'(sel_op);
                a_q  <= sel_a;
                b_q  <= sel_b;
                id_q <= grant_idx;
            end
            if (state_q == CAPTURE) begin
                result_q <= packed_out.result;
                carry_q  <= packed_out.carry;
            end
        end
    end

    assign req_ready  = accept ? grant : '0;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign rsp_carry  = carry_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: directed scenarios plus random traffic, each cycle
// compared against a transaction-level model of grant order and response timing.
module tb_alu_scheduler;

    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_ready;
    logic [2*N-1:0] req_op;
    logic [4*N-1:0] req_a, req_b;
    logic           rsp_valid, rsp_ready;
    logic [0:0]     rsp_id;
    logic [3:0]     rsp_result;
    logic           rsp_carry, busy;

    alu_scheduler #(.N_REQ(N), .DATA_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    bit pend [N];
    int p_op [N], p_a [N], p_b [N];
    int ptr = N - 1;
    bit in_flight = 0;
    int gcyc = 0, e_id = 0, e_res = 0, e_car = 0;
    int cyc = 0;
    bit drv_rst = 0, drv_rdy = 1;
    int grant_log[$], grant_cyc[$], rsp_log[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic void ref_alu(input int op, input int a, input int b,
                                    output int res, output int car);
        res = 0;
        car = 0;
        case (op)
            0: begin res = (a + b) % 16;      car = (a + b >= 16) ? 1 : 0; end
            1: begin res = (a + 16 - b) % 16; car = (a >= b) ? 1 : 0;      end
            2: res = ((b > a) ? 4 : 0) + ((a == b) ? 2 : 0) + ((a > b) ? 1 : 0);
            default: res = a & b;
        endcase
    endfunction

    function automatic bit any_pend();
        bit r = 0;
        for (int i = 0; i < N; i++) r |= pend[i];
        return r;
    endfunction

    task automatic step();
        int win;
        bit rv;
        @(posedge clk); #1;
        cyc++;
        rst_n     = drv_rst;
        rsp_ready = drv_rdy;
        for (int i = 0; i < N; i++) begin
            req_valid[i]     = pend[i];
            req_op[2*i +: 2] = 2'(p_op[i]);
            req_a[4*i +: 4]  = 4'(p_a[i]);
            req_b[4*i +: 4]  = 4'(p_b[i]);
        end
        @(negedge clk);
        win = -1;
        if (rst_n && !in_flight)
            for (int k = 1; k <= N; k++)
                if (win < 0 && pend[(ptr + k) % N]) win = (ptr + k) % N;
        check_eq("req_ready", 32'(req_ready), (win >= 0) ? (32'd1 << win) : 32'd0);
        check_eq("busy", 32'(busy), 32'(in_flight));
        rv = in_flight && (cyc >= gcyc + 3);
        check_eq("rsp_valid", 32'(rsp_valid), 32'(rv));
        if (rv) begin
            check_eq("rsp_id", 32'(rsp_id), 32'(e_id));
            check_eq("rsp_result", 32'(rsp_result), 32'(e_res));
            check_eq("rsp_carry", 32'(rsp_carry), 32'(e_car));
        end
        for (int i = 0; i < N; i++)
            if (req_ready[i]) begin grant_log.push_back(i); grant_cyc.push_back(cyc); end
        if (rsp_valid && rsp_ready) rsp_log.push_back(int'(rsp_id));
        if (!rst_n) begin
            in_flight = 0;
            ptr = N - 1;
        end else if (win >= 0) begin
            in_flight = 1;
            gcyc = cyc;
            e_id = win;
            ref_alu(p_op[win], p_a[win], p_b[win], e_res, e_car);
            pend[win] = 0;
            ptr = win;
        end else if (rv && rsp_ready) begin
            in_flight = 0;
        end
    endtask

    task automatic post(input int i, input int op, input int a, input int b);
        pend[i] = 1; p_op[i] = op; p_a[i] = a; p_b[i] = b;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        drv_rdy = 1;
        while ((in_flight || any_pend()) && n < limit) begin step(); n++; end
        check_eq("drain_timeout", 32'(in_flight || any_pend()), 32'd0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) pend[i] = 0;
        drv_rst = 0; step(); step();
        drv_rst = 1;
    endtask

    task automatic do_op(input int i, input int op, input int a, input int b);
        post(i, op, a, b);
        drain(40);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; rsp_ready = 1'b1;
        req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
        for (int i = 0; i < N; i++) begin pend[i] = 0; p_op[i] = 0; p_a[i] = 0; p_b[i] = 0; end

        do_reset();
        check_eq("reset_rsp_result", 32'(rsp_result), 32'd0);
        check_eq("reset_rsp_id", 32'(rsp_id), 32'd0);

        // Directed cases from the reference scenarios
        grant_cyc.delete();
        do_op(0, 0, 9, 8);
        do_op(1, 1, 3, 5);
        do_op(1, 1, 5, 3);
        do_op(0, 2, 6, 6);
        do_op(0, 2, 7, 2);
        do_op(0, 2, 2, 7);
        do_op(0, 0, 15, 1);
        do_op(1, 1, 0, 0);

        // AND under 5 cycles of backpressure with another requester waiting
        post(0, 3, 4'b1100, 4'b1010);
        post(1, 0, 2, 3);
        drv_rdy = 0;
        n = 0;
        while (!(in_flight && cyc >= gcyc + 3) && n < 20) begin step(); n++; end
        check_eq("resp_reach_timeout", 32'(in_flight && cyc >= gcyc + 3), 32'd1);
        repeat (5) step();
        drain(40);

        // Both requesters continuously valid from reset
        do_reset();
        grant_log.delete(); grant_cyc.delete(); rsp_log.delete();
        repeat (16) begin
            for (int i = 0; i < N; i++)
                if (!pend[i]) post(i, $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15));
            step();
        end
        drain(40);
        check_eq("alt_grant_count", 32'(grant_log.size() >= 4), 32'd1);
        for (int k = 0; k < 4 && k < grant_log.size(); k++) begin
            check_eq("alt_grant_order", 32'(grant_log[k]), 32'(k % 2));
            check_eq("alt_rsp_order", 32'(rsp_log[k]), 32'(k % 2));
            if (k > 0) check_eq("alt_spacing", 32'(grant_cyc[k] - grant_cyc[k-1]), 32'd4);
        end

        // Reset asserted while the operation is in CAPTURE
        post(1, 0, 1, 1);
        n = 0;
        while (!in_flight && n < 20) begin step(); n++; end
        check_eq("grant_timeout", 32'(in_flight), 32'd1);
        step();
        drv_rst = 0; step();
        drv_rst = 1;
        repeat (4) step();
        grant_log.delete();
        post(1, 1, 9, 4);
        post(0, 2, 3, 3);
        drain(40);
        check_eq("post_reset_first_grant", 32'(grant_log.size() > 0 ? grant_log[0] : 99), 32'd0);

        // Random traffic with random backpressure and occasional withdrawals
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0)
                    post(i, $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15));
                else if (pend[i] && $urandom_range(0, 19) == 0)
                    pend[i] = 0;
            end
            drv_rdy = ($urandom_range(0, 3) != 0);
            step();
        end
        drain(60);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Sequencing and arbitration front end for the shared 4-bit combinational ALU (`alu_verilog`): add, subtract, compare, AND. Accepts operation requests from N_REQ independent requesters over valid/ready channels and grants them round-robin. Drives the ALU select and operand inputs from registers, then returns one result per operation on a single tagged response channel. Only one operation is in flight at a time.

## Interface
- N_REQ, default 2: number of requesters; supported range 2..4.
- DATA_W, default 4: operand width; fixed to the ALU width, only 4 supported.

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept; one-hot or zero
- req_op  in  2*N_REQ  op per requester, slice i at [2i+1:2i]; 00 add, 01 sub, 10 compare, 11 AND; bit1 maps to s1, bit0 to s0
- req_a, req_b  in  DATA_W*N_REQ  operands, slice i at [4i+3:4i]
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  $clog2(N_REQ)  index of the requester served
- rsp_result  out  DATA_W  packed result
- rsp_carry  out  1  carry/no-borrow flag
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - If any req_valid is high, the arbiter picks winner i and asserts req_ready[i] combinationally in the same cycle.
  - At the clock edge, op/A/B/id of requester i are latched and the FSM moves to ISSUE.
  - With no request, the FSM stays in IDLE.
- ISSUE: the latched op drives ALU s1/s0 and the latched A/B drive the ALU operand inputs. The ALU settles. Next state is CAPTURE.
- CAPTURE: the ALU outputs are packed and registered. Next state is RESP.
- RESP:
  - rsp_valid is 1; rsp_id, rsp_result and rsp_carry are stable while rsp_valid is high.
  - On rsp_valid & rsp_ready the FSM moves to IDLE.
  - Otherwise it holds indefinitely.
- Result packing:
  - add/sub: result = SAS, carry = CAS.
  - For sub, carry = 1 means A >= B (no borrow); the result is A - B mod 16.
  - compare: result = {1'b0, b_greater_a, aeqb, a_greater_b}, carry = 0.
  - AND: result = a_and_b, carry = 0.
- Round-robin arbitration:
  - A last-grant pointer updates on each grant.
  - Search starts at pointer+1 and wraps at N_REQ-1 → 0.
  - Reset value of the pointer is N_REQ-1, so requester 0 has first priority.
- req_ready is never asserted outside IDLE. Requesters hold req_valid and their payload stable until accepted.
- req_valid dropping before grant is legal; the request is simply not served.

## Timing
- Reset (rst_n low at an edge):
  - state = IDLE, pointer = N_REQ-1.
  - Operand, op, id and result registers = 0.
  - rsp_valid = 0, req_ready = 0, busy = 0.
- Reset mid-operation (any state): the in-flight operation is dropped and no response is issued. After rst_n goes high, the first grant goes to requester 0.
- Latency:
  - Grant in cycle T.
  - ISSUE in T+1, CAPTURE in T+2.
  - rsp_valid high from T+3.
- Throughput: with rsp_ready tied high, one operation per 4 cycles. The next grant comes in the cycle after the response handshake, never in the same cycle.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep req_valid and are served in round-robin order.
- A single requester requesting continuously is granted every 4 cycles; its grant is not delayed by the pointer position.
- Backpressure: rsp_ready low holds RESP, with all response outputs and busy unchanged.
- The ALU inputs change only on the edge that enters ISSUE.

## Structure
- Package alu_sched_pkg holds:
  - op encodings (OP_ADD=2'b00, OP_SUB=2'b01, OP_CMP=2'b10, OP_AND=2'b11);
  - the FSM state enum;
  - the result-packing function.
- Sub-module rr_arbiter (parameter N_REQ) has:
  - inputs: req vector, advance strobe;
  - outputs: one-hot grant, grant index;
  - its own pointer register, with the same reset.
- alu_scheduler instantiates rr_arbiter and alu_verilog, plus the FSM and the registers.

## Test plan
- Reset then a single add from requester 0, A=9, B=8: grant cycle T; at T+3 rsp_valid=1, rsp_id=0, rsp_result=4'b0001, rsp_carry=1.
- Sub from requester 1, A=3, B=5: rsp_result=4'b1110, rsp_carry=0. Then A=5, B=3: rsp_result=4'b0010, rsp_carry=1.
- Compare A=6, B=6 → rsp_result=4'b0010. A=7, B=2 → 4'b0001. A=2, B=7 → 4'b0100. rsp_carry=0 in all three cases.
- AND A=4'b1100, B=4'b1010 → rsp_result=4'b1000. Hold rsp_ready low for 5 cycles: outputs stay stable, busy=1, req_ready=0 throughout.
- Both requesters valid continuously from reset: grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1; spacing is 4 cycles with rsp_ready=1.
- Assert rst_n=0 during CAPTURE: the next cycle has busy=0 and rsp_valid=0, and no stale response appears. Re-request from both requesters: requester 0 is granted first.
